// File: rtl/data_sram_responder.sv
// Responder end of the data SRAM port: one-cycle registered reads, byte-masked writes,
// a post-reset clear sweep, and out-of-range flagging. Define DSRAM_WR_FWD_EN for write-first rdata.
module data_sram_responder #(
    parameter int          ADDR_W   = 10,
    parameter logic [31:0] INIT_VAL = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_we,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic        init_done,
    output logic        addr_err,
    output logic [7:0]  err_cnt
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] idx_nxt;

    logic [31:0]       mem [DEPTH];

    logic [ADDR_W-1:0] word_idx;
    logic              in_range;
    logic              rd_ok;
    logic              oor;
    logic [31:0]       old_word;
    logic [31:0]       merged_word;
    logic [ADDR_W-1:0] wr_idx;
    logic [31:0]       wr_data;
    logic [3:0]        wr_be;
    logic              addr_lsb_unused;

    // Byte offset bits never select anything; the array is word-organised.
    assign addr_lsb_unused = ^data_sram_addr[1:0];

    assign word_idx  = data_sram_addr[ADDR_W+1:2];
    assign in_range  = (data_sram_addr[31:ADDR_W+2] == '0);
    assign rd_ok     = (state == ST_READY) && data_sram_en && in_range;
    assign oor       = (state == ST_READY) && data_sram_en && !in_range;
    assign old_word  = mem[word_idx];
    assign init_done = (state == ST_READY);

    always_comb begin
        merged_word = old_word;
        for (int i = 0; i < 4; i++) begin
            if (data_sram_we[i]) merged_word[8*i +: 8] = data_sram_wdata[8*i +: 8];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= ST_CLEAR;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    // The sweep owns the write port while clearing; core requests are dropped.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        wr_idx    = word_idx;
        wr_data   = data_sram_wdata;
        wr_be     = 4'b0000;
        case (state)
            ST_CLEAR: begin
                wr_idx  = idx;
                wr_data = INIT_VAL;
                wr_be   = 4'b1111;
                idx_nxt = idx + 1'b1;
                if (idx == {ADDR_W{1'b1}}) state_nxt = ST_READY;
            end
            ST_READY: begin
                if (rd_ok) wr_be = data_sram_we;
            end
            default: state_nxt = ST_CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (wr_be[i]) mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            data_sram_rdata <= 32'h0;
        end else if (oor) begin
            data_sram_rdata <= 32'h0;
        end else if (rd_ok) begin
`ifdef DSRAM_WR_FWD_EN
            data_sram_rdata <= merged_word;
`else
            data_sram_rdata <= old_word;
`endif
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            addr_err <= 1'b0;
            err_cnt  <= 8'h00;
        end else if (oor) begin
            addr_err <= 1'b1;
            if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'h01;
        end
    end

endmodule

// File: tb/tb_data_sram_responder.sv
// Scoreboard bench for data_sram_responder (ADDR_W=4): reset/sweep timing, reads, byte writes,
// read-first vs write-first rdata (DSRAM_WR_FWD_EN), out-of-range saturation, mid-sweep reset.
module tb_data_sram_responder;

    localparam int          AW   = 4;
    localparam int          NW   = 1 << AW;
    localparam logic [31:0] INIT = 32'hA5A5_0F0F;

    logic        clk;
    logic        resetn;
    logic        data_sram_en;
    logic [3:0]  data_sram_we;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;
    logic        init_done;
    logic        addr_err;
    logic [7:0]  err_cnt;

    int errors = 0;
    int checks = 0;

    logic [31:0] exp_q[$];
    logic [31:0] model_mem [NW];
    logic [31:0] m_rdata;
    logic        m_err;
    logic [7:0]  m_cnt;

    data_sram_responder #(.ADDR_W(AW), .INIT_VAL(INIT)) dut (
        .clk             (clk),
        .resetn          (resetn),
        .data_sram_en    (data_sram_en),
        .data_sram_we    (data_sram_we),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata),
        .data_sram_rdata (data_sram_rdata),
        .init_done       (init_done),
        .addr_err        (addr_err),
        .err_cnt         (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%08h expected=%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < NW; i++) model_mem[i] = INIT;
        m_rdata = 32'h0;
        m_err   = 1'b0;
        m_cnt   = 8'h00;
        exp_q.delete();
    endtask

    // One request, driven at the falling edge, result checked just after the next rising edge.
    task automatic access(input logic en_i, input logic [3:0] we_i,
                          input logic [31:0] addr_i, input logic [31:0] wdata_i);
        logic [31:0] old_w;
        logic [31:0] new_w;
        @(negedge clk);
        data_sram_en    = en_i;
        data_sram_we    = we_i;
        data_sram_addr  = addr_i;
        data_sram_wdata = wdata_i;
        if (en_i) begin
            if (addr_i[31:AW+2] == '0) begin
                old_w = model_mem[addr_i[AW+1:2]];
                new_w = old_w;
                for (int b = 0; b < 4; b++)
                    if (we_i[b]) new_w[8*b +: 8] = wdata_i[8*b +: 8];
`ifdef DSRAM_WR_FWD_EN
                m_rdata = new_w;
`else
                m_rdata = old_w;
`endif
                model_mem[addr_i[AW+1:2]] = new_w;
            end else begin
                m_rdata = 32'h0;
                m_err   = 1'b1;
                if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'h01;
            end
        end
        exp_q.push_back(m_rdata);
        @(posedge clk);
        #1;
        check("rdata", data_sram_rdata, exp_q.pop_front());
        check("addr_err", {31'b0, addr_err}, {31'b0, m_err});
        check("err_cnt", {24'b0, err_cnt}, {24'b0, m_cnt});
        data_sram_en = 1'b0;
    endtask

    task automatic reset_check();
        @(negedge clk);
        resetn = 1'b0;
        #1;
        check("rst_rdata", data_sram_rdata, 32'h0);
        check("rst_init_done", {31'b0, init_done}, 32'h0);
        check("rst_addr_err", {31'b0, addr_err}, 32'h0);
        check("rst_err_cnt", {24'b0, err_cnt}, 32'h0);
    endtask

    // Called right after resetn rises at a falling edge; requests during the sweep must be ignored.
    task automatic sweep_check();
        check("sweep_init_done_0", {31'b0, init_done}, 32'h0);
        for (int k = 1; k <= NW; k++) begin
            data_sram_en    = 1'b1;
            data_sram_we    = 4'b1111;
            data_sram_addr  = (k % 3 == 0) ? 32'h0000_1000 : 32'h0000_0000;
            data_sram_wdata = $urandom;
            @(posedge clk);
            #1;
            check("sweep_init_done", {31'b0, init_done}, (k == NW) ? 32'h1 : 32'h0);
            check("sweep_rdata", data_sram_rdata, 32'h0);
            check("sweep_addr_err", {31'b0, addr_err}, 32'h0);
            check("sweep_err_cnt", {24'b0, err_cnt}, 32'h0);
        end
        data_sram_en = 1'b0;
        data_sram_we = 4'b0000;
        model_clear();
    endtask

    initial begin
        resetn          = 1'b0;
        data_sram_en    = 1'b0;
        data_sram_we    = 4'b0000;
        data_sram_addr  = 32'h0;
        data_sram_wdata = 32'h0;
        model_clear();

        reset_check();
        @(negedge clk);
        resetn = 1'b1;
        sweep_check();

        for (int i = 0; i < NW; i++) access(1'b1, 4'b0000, 32'(i * 4), 32'h0);

        access(1'b1, 4'b1111, 32'h0000_0008, 32'hDEAD_BEEF);
        access(1'b1, 4'b0000, 32'h0000_0008, 32'h0);
        access(1'b1, 4'b0000, 32'h0000_000A, 32'h0);
        check("deadbeef_direct", data_sram_rdata, 32'hDEAD_BEEF);

        access(1'b1, 4'b1111, 32'h0000_000C, 32'h1122_3344);
        access(1'b1, 4'b0010, 32'h0000_000C, 32'h0000_AA00);
        access(1'b1, 4'b0000, 32'h0000_000C, 32'h0);
        check("partial_direct", data_sram_rdata, 32'h1122_AA44);

        access(1'b1, 4'b1111, 32'h0000_0014, 32'h1122_3344);
        access(1'b1, 4'b0001, 32'h0000_0014, 32'h0000_0055);
`ifdef DSRAM_WR_FWD_EN
        check("fwd_direct", data_sram_rdata, 32'h1122_3355);
`else
        check("fwd_direct", data_sram_rdata, 32'h1122_3344);
`endif
        access(1'b0, 4'b1111, 32'h0000_0014, 32'hFFFF_FFFF);
        access(1'b1, 4'b0000, 32'h0000_0014, 32'h0);

        for (int i = 0; i < 60; i++) begin
            logic [31:0] a;
            a = {26'b0, 6'($urandom_range(0, 63))};
            if ($urandom_range(0, 7) == 0) a = a | 32'h0000_0400;
            access(1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), a, $urandom);
        end

        access(1'b1, 4'b0000, 32'h0000_1000, 32'h0);
        for (int i = 0; i < 300; i++) access(1'b1, 4'b1111, 32'h0000_1000, $urandom);
        check("err_cnt_sat", {24'b0, err_cnt}, 32'h0000_00FF);
        for (int i = 0; i < NW; i++) access(1'b1, 4'b0000, 32'(i * 4), 32'h0);

        reset_check();
        @(negedge clk);
        resetn = 1'b1;
        repeat (7) @(posedge clk);
        reset_check();
        @(negedge clk);
        resetn = 1'b1;
        sweep_check();
        for (int i = 0; i < NW; i++) access(1'b1, 4'b0000, 32'(i * 4), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
